// File: rtl/mean_shift_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined unsigned multiplier between
// N_REQ requesters. A shadow pipeline carries each product's owner ID
// alongside the multiplier. A result that its owner does not accept
// freezes the whole multiplier through mul_ce.
module mean_shift_mul_arbiter #(
   parameter int unsigned N_REQ       = 2,
   parameter int unsigned ID_W        = 1,
   parameter int unsigned MUL_LATENCY = 3,
   parameter int unsigned DIN_W       = 16,
   parameter int unsigned DOUT_W      = 19
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*DIN_W-1:0] req_a,
   input  logic [N_REQ*DIN_W-1:0] req_b,
   output logic [N_REQ-1:0]       rsp_valid,
   input  logic [N_REQ-1:0]       rsp_ready,
   output logic [DOUT_W-1:0]      rsp_data,
   output logic                   mul_ce,
   output logic [DIN_W-1:0]       mul_din0,
   output logic [DIN_W-1:0]       mul_din1,
   input  logic [DOUT_W-1:0]      mul_dout,
   output logic [ID_W+1:0]        inflight
);

   logic [ID_W-1:0]        ptr;
   logic [ID_W-1:0]        winner;
   logic                   found;
   logic                   stall;
   logic                   issue;
   logic                   retire;
   logic                   tail_vld;
   logic [ID_W-1:0]        tail_id;
   logic [MUL_LATENCY-1:0] pipe_vld;
   logic [ID_W-1:0]        pipe_id [MUL_LATENCY];

   // The tail stage lines up with mul_dout.
   assign tail_vld = pipe_vld[MUL_LATENCY-1];
   assign tail_id  = pipe_id[MUL_LATENCY-1];

   // An unaccepted result freezes the entire multiplier, so every other requester waits too.
   assign stall    = tail_vld && !rsp_ready[tail_id];
   assign retire   = tail_vld &&  rsp_ready[tail_id];
   assign mul_ce   = !stall;

   // Grants are held off while reset is asserted so no handshake is seen.
   assign issue    = found && !stall && reset_n;

   assign rsp_data = mul_dout;

   // Round-robin search: the first valid requester at or after ptr, wrapping around.
   always_comb begin
      int unsigned idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         idx = 32'(ptr) + k;
         if (idx >= N_REQ) begin
            idx = idx - N_REQ;
         end
         if (!found && req_valid[idx[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[ID_W-1:0];
         end
      end
   end

   // Only the winner sees ready. It drops while the pipe is stalled.
   always_comb begin
      req_ready = '0;
      if (issue) begin
         req_ready[winner] = 1'b1;
      end
   end

   // Operand steering. With no winner this falls back to requester 0, which is harmless because stage 0 loads vld=0.
   always_comb begin
      mul_din0 = req_a[DIN_W-1:0];
      mul_din1 = req_b[DIN_W-1:0];
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (winner == ID_W'(i)) begin
            mul_din0 = req_a[i*DIN_W +: DIN_W];
            mul_din1 = req_b[i*DIN_W +: DIN_W];
         end
      end
   end

   // Result valid is routed straight from the tail stage to its owner.
   always_comb begin
      rsp_valid = '0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         rsp_valid[i] = tail_vld && (tail_id == ID_W'(i));
      end
   end

   // Shadow pipeline of {vld, id}. It advances in lockstep with the multiplier's ce.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_vld <= '0;
         for (int unsigned s = 0; s < MUL_LATENCY; s++) begin
            pipe_id[s] <= '0;
         end
      end else if (mul_ce) begin
         pipe_vld[0] <= issue;
         pipe_id[0]  <= winner;
         for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_id[s]  <= pipe_id[s-1];
         end
      end
   end

   // On each issue, the round-robin pointer moves to the requester just after the winner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ptr <= '0;
      end else if (issue) begin
         if (winner == ID_W'(N_REQ - 1)) begin
            ptr <= '0;
         end else begin
            ptr <= winner + ID_W'(1);
         end
      end
   end

   // Count of products issued but not yet retired.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight <= '0;
      end else begin
         case ({issue, retire})
            2'b10:   inflight <= inflight + (ID_W+2)'(1);
            2'b01:   inflight <= inflight - (ID_W+2)'(1);
            default: inflight <= inflight;
         endcase
      end
   end

endmodule

// File: tb/tb_mean_shift_mul_arbiter.sv
// Directed testbench for mean_shift_mul_arbiter (N_REQ=2, latency 3), with a behavioural 3-stage multiplier.
module tb_mean_shift_mul_arbiter;

   logic        clk;
   logic        reset_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [18:0] rsp_data;
   logic        mul_ce;
   logic [15:0] mul_din0;
   logic [15:0] mul_din1;
   logic [18:0] mul_dout;
   logic [2:0]  inflight;

   int checks = 0;
   int errors = 0;

   mean_shift_mul_arbiter #(
      .N_REQ(2), .ID_W(1), .MUL_LATENCY(3), .DIN_W(16), .DOUT_W(19)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1),
      .mul_dout(mul_dout), .inflight(inflight)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Multiplier model: operand register, product register, then output register, all gated by ce.
   logic [15:0] ma = '0;
   logic [15:0] mb = '0;
   logic [18:0] mp = '0;
   initial mul_dout = '0;
   always @(posedge clk) begin
      if (mul_ce) begin
         ma       <= mul_din0;
         mb       <= mul_din1;
         mp       <= 19'({16'h0, ma} * {16'h0, mb});
         mul_dout <= mp;
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      reset_n   = 1'b0;
      req_valid = 2'b00;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      req_a     = {16'd1, 16'd1};
      req_b     = {16'd1, 16'd1};
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
      checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL reset_mul_ce: got %b expected 1", mul_ce); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight: got %0d expected 0", inflight); end
      @(negedge clk);
      req_valid = 2'b00;
      reset_n   = 1'b1;
   endtask

   task automatic test_single_op();
      apply_reset();
      rsp_ready = 2'b11;
      @(negedge clk);
      req_valid = 2'b01; req_a[15:0] = 16'd300; req_b[15:0] = 16'd200;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready: got %b expected 01", req_ready); end
      checks++; if (mul_din0 !== 16'd300 || mul_din1 !== 16'd200) begin errors++; $display("FAIL single_operands: got %0d,%0d expected 300,200", mul_din0, mul_din1); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (inflight !== 3'd1) begin errors++; $display("FAIL single_inflight1: got %0d expected 1", inflight); end
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early_rsp: got %b expected 00", rsp_valid); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_early_rsp2: got %b expected 00", rsp_valid); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); end
      checks++; if (rsp_data !== 19'd60000) begin errors++; $display("FAIL single_rsp_data: got %0d expected 60000", rsp_data); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL single_rsp_clear: got %b expected 00", rsp_valid); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL single_inflight0: got %0d expected 0", inflight); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_rdy;
      logic [1:0]  exp_rv;
      logic [18:0] exp_data;
      int          iss;
      int          ret;
      apply_reset();
      rsp_ready = 2'b11;
      req_a = {16'd5, 16'd2};
      req_b = {16'd7, 16'd3};
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         req_valid = (c < 6) ? 2'b11 : 2'b00;
         #1;
         exp_rdy  = (c < 6) ? ((c % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         exp_rv   = (c >= 3 && c < 9) ? (((c - 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
         exp_data = ((c - 3) % 2 == 0) ? 19'd6 : 19'd35;
         iss      = (c < 6) ? c : 6;
         ret      = (c < 3) ? 0 : ((c - 3 < 6) ? c - 3 : 6);
         checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, exp_rdy); end
         checks++; if (rsp_valid !== exp_rv) begin errors++; $display("FAIL rr_rsp_valid c=%0d: got %b expected %b", c, rsp_valid, exp_rv); end
         if (exp_rv != 2'b00) begin
            checks++; if (rsp_data !== exp_data) begin errors++; $display("FAIL rr_rsp_data c=%0d: got %0d expected %0d", c, rsp_data, exp_data); end
         end
         checks++; if (inflight !== 3'(iss - ret)) begin errors++; $display("FAIL rr_inflight c=%0d: got %0d expected %0d", c, inflight, iss - ret); end
      end
   endtask

   task automatic test_truncation();
      apply_reset();
      rsp_ready = 2'b11;
      @(negedge clk);
      req_valid = 2'b01; req_a[15:0] = 16'hFFFF; req_b[15:0] = 16'hFFFF;
      @(negedge clk);
      req_valid = 2'b10; req_a[31:16] = 16'hFFFF; req_b[31:16] = 16'd2;
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL trunc_grant1: got %b expected 10", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 19'h60001) begin errors++; $display("FAIL trunc_ffff: got %b/%h expected 01/60001", rsp_valid, rsp_data); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== 19'h1FFFE) begin errors++; $display("FAIL trunc_x2: got %b/%h expected 10/1fffe", rsp_valid, rsp_data); end
   endtask

   task automatic test_backpressure();
      logic [18:0] exp_d [3];
      exp_d[0] = 19'd110; exp_d[1] = 19'd156; exp_d[2] = 19'd210;
      apply_reset();
      rsp_ready = 2'b01;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 2'b10;
         req_a[31:16] = 16'(10 + 2 * c);
         req_b[31:16] = 16'(11 + 2 * c);
         #1;
         checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_issue c=%0d: got %b expected 10", c, req_ready); end
      end
      for (int c = 3; c < 8; c++) begin
         @(negedge clk);
         req_valid = 2'b01;
         #1;
         checks++; if (rsp_valid !== 2'b10 || rsp_data !== 19'd110) begin errors++; $display("FAIL bp_hold c=%0d: got %b/%0d expected 10/110", c, rsp_valid, rsp_data); end
         checks++; if (mul_ce !== 1'b0) begin errors++; $display("FAIL bp_ce c=%0d: got %b expected 0", c, mul_ce); end
         checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready c=%0d: got %b expected 00", c, req_ready); end
         checks++; if (inflight !== 3'd3) begin errors++; $display("FAIL bp_inflight c=%0d: got %0d expected 3", c, inflight); end
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         req_valid = 2'b00;
         rsp_ready = 2'b11;
         #1;
         checks++; if (rsp_valid !== 2'b10 || rsp_data !== exp_d[c]) begin errors++; $display("FAIL bp_drain c=%0d: got %b/%0d expected 10/%0d", c, rsp_valid, rsp_data, exp_d[c]); end
         checks++; if (mul_ce !== 1'b1) begin errors++; $display("FAIL bp_drain_ce c=%0d: got %b expected 1", c, mul_ce); end
         checks++; if (inflight !== 3'(3 - c)) begin errors++; $display("FAIL bp_drain_inflight c=%0d: got %0d expected %0d", c, inflight, 3 - c); end
      end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b00 || inflight !== 3'd0) begin errors++; $display("FAIL bp_empty: got %b/%0d expected 00/0", rsp_valid, inflight); end
   endtask

   task automatic test_mixed_stall();
      apply_reset();
      rsp_ready = 2'b10;
      @(negedge clk);
      req_valid = 2'b01; req_a[15:0] = 16'd4; req_b[15:0] = 16'd5;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mix_grant0: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      @(negedge clk);
      for (int c = 3; c < 5; c++) begin
         @(negedge clk);
         req_valid = 2'b10; req_a[31:16] = 16'd6; req_b[31:16] = 16'd7;
         #1;
         checks++; if (rsp_valid !== 2'b01 || rsp_data !== 19'd20) begin errors++; $display("FAIL mix_hold c=%0d: got %b/%0d expected 01/20", c, rsp_valid, rsp_data); end
         checks++; if (req_ready !== 2'b00 || mul_ce !== 1'b0) begin errors++; $display("FAIL mix_blocked c=%0d: got ready=%b ce=%b expected 00/0", c, req_ready, mul_ce); end
      end
      @(negedge clk);
      rsp_ready = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b10 || mul_ce !== 1'b1) begin errors++; $display("FAIL mix_release: got ready=%b ce=%b expected 10/1", req_ready, mul_ce); end
      checks++; if (rsp_valid !== 2'b01 || inflight !== 3'd1) begin errors++; $display("FAIL mix_retire: got %b/%0d expected 01/1", rsp_valid, inflight); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (rsp_valid !== 2'b00 || inflight !== 3'd1) begin errors++; $display("FAIL mix_after: got %b/%0d expected 00/1", rsp_valid, inflight); end
      @(negedge clk);
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b10 || rsp_data !== 19'd42) begin errors++; $display("FAIL mix_req1_rsp: got %b/%0d expected 10/42", rsp_valid, rsp_data); end
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      rsp_ready = 2'b11;
      @(negedge clk);
      req_valid = 2'b01; req_a[15:0] = 16'd3; req_b[15:0] = 16'd3;
      @(negedge clk);
      req_a[15:0] = 16'd4; req_b[15:0] = 16'd4;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmo_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      checks++; if (inflight !== 3'd2) begin errors++; $display("FAIL rmo_inflight2: got %0d expected 2", inflight); end
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 2'b01 || rsp_data !== 19'd9) begin errors++; $display("FAIL rmo_pre_rsp: got %b/%0d expected 01/9", rsp_valid, rsp_data); end
      reset_n = 1'b0;
      #1;
      checks++; if (rsp_valid !== 2'b00 || inflight !== 3'd0) begin errors++; $display("FAIL rmo_async: got %b/%0d expected 00/0", rsp_valid, inflight); end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL rmo_spurious c=%0d: got %b expected 00", c, rsp_valid); end
      end
      @(negedge clk);
      req_valid = 2'b11;
      #1;
      checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmo_first_grant: got %b expected 01", req_ready); end
      @(negedge clk);
      req_valid = 2'b00;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      reset_n   = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      req_a     = '0;
      req_b     = '0;
      test_reset();
      test_single_op();
      test_round_robin();
      test_truncation();
      test_backpressure();
      test_mixed_stall();
      test_reset_mid_op();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete within 100000 time units");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mean_shift_mul_arbiter.md
Name: mean_shift_mul_arbiter

Overview:
- Shares one pipelined unsigned 16x16->19 multiplier between N_REQ requesters inside the mean-shift accelerator.
- Arbitrates operand requests round-robin and drives the multiplier's din0/din1/ce.
- Tracks each in-flight product's requester ID in a shadow pipeline.
- Steers each result back to its owner, with backpressure implemented by stalling the whole multiplier via ce.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- ID_W, 1, requester ID width; must equal max(1, ceil(log2(N_REQ))).
- MUL_LATENCY, 3, ce-enabled clock edges from operand presentation to product at mul_dout (a/b reg, product reg, output reg).
- DIN_W, 16, operand width.
- DOUT_W, 19, product width; the product is truncated to DOUT_W LSBs by the multiplier.

Ports:
- clk  in  1  Rising-edge clock.
- reset_n  in  1  Asynchronous active-low reset.
- req_valid  in  N_REQ  Per-requester operand valid.
- req_ready  out  N_REQ  Per-requester grant; transfer occurs when req_valid[i] && req_ready[i].
- req_a  in  N_REQ*DIN_W  Packed operand A; requester i uses slice [i*DIN_W +: DIN_W].
- req_b  in  N_REQ*DIN_W  Packed operand B, same packing.
- rsp_valid  out  N_REQ  One-hot (or zero) result valid.
- rsp_ready  in  N_REQ  Per-requester result accept.
- rsp_data  out  DOUT_W  Result, shared by all requesters; equals mul_dout.
- mul_ce  out  1  Multiplier clock enable.
- mul_din0  out  DIN_W  Multiplier operand 0.
- mul_din1  out  DIN_W  Multiplier operand 1.
- mul_dout  in  DOUT_W  Multiplier product.
- inflight  out  ID_W+2  Count of issued, not-yet-retired products (0..MUL_LATENCY).

Behaviour:
- Shadow pipeline: MUL_LATENCY stages of {vld, id}, advanced only when mul_ce=1. Stage 0 loads {issue, grant_id}; the tail is stage MUL_LATENCY-1, which is aligned with mul_dout.
- Stall: stall = tail_vld && !rsp_ready[tail_id]. mul_ce = !stall. The whole pipe freezes; the multiplier holds mul_dout because its own ce is low.
- Response: rsp_valid[i] = tail_vld && (tail_id == i); combinational, with no extra register. rsp_data = mul_dout. A result retires when rsp_valid[i] && rsp_ready[i].
- Grant is combinational from req_valid and the rr pointer:
  - Winner is the first i with req_valid[i], searching from ptr upward and wrapping modulo N_REQ.
  - req_ready[winner] = !stall; all other req_ready bits are 0.
  - issue = any req_valid && !stall.
- Operands: mul_din0/mul_din1 = req_a/req_b slice of the winner. When there is no winner they are the slices of requester 0 (don't-care, since stage 0 vld=0).
- RR pointer: on issue, ptr <= (winner+1) mod N_REQ. Otherwise ptr holds.
- Throughput: one issue per cycle when unstalled. A requester holding req_valid continuously receives every N_REQ-th grant when all requesters are active.
- Latency: an operand accepted at edge E produces rsp_valid during the cycle after edge E+MUL_LATENCY-1, assuming no stalls. That is MUL_LATENCY cycles from handshake to response.
- inflight:
  - +1 on issue, -1 on retire, unchanged when both occur in the same cycle.
  - Never exceeds MUL_LATENCY; a stall blocks new issue, so inflight cannot grow past the pipe depth.
- Simultaneous events: a retire and a new issue in the same cycle are legal (ce=1). A requester may issue and receive a result in the same cycle.
- Backpressure: a response stalled on requester j also blocks all other requesters' issue. This is intended; no reordering is performed.
- Reset (async assert, sync release):
  - Outputs: ptr=0, all shadow vld=0, inflight=0.
  - Hence rsp_valid=0, req_ready=0 while reset is asserted, mul_ce=1.
  - Reset mid-operation discards in-flight products. Stale mul_dout is ignored because vld=0.
- Requesters must hold req_valid and operands stable until ready; the arbiter does not check this.

Test Plan:
- Single op: requester 0 sends a=300, b=200, rsp_ready=1 → req_ready[0]=1 the same cycle; 3 cycles later rsp_valid=2'b01, rsp_data=60000; inflight goes 1 → 0.
- Round-robin: both requesters valid continuously, a0=2,b0=3 and a1=5,b1=7 → grants alternate 0,1,0,1 starting from 0; responses alternate 6,35 with matching rsp_valid bits.
- Truncation: a=b=16'hFFFF → rsp_data = 0xFFFE0001 & 0x7FFFF = 19'h60001.
- Backpressure: issue 3 back-to-back ops from requester 1 with rsp_ready[1]=0 → first result holds for 5 cycles, mul_ce=0, req_ready=0, inflight=3; raising rsp_ready[1] drains 3 results on consecutive cycles in order.
- Mixed stall: requester 0's result stalls while requester 1 is waiting → requester 1 is not granted until requester 0 retires; then requester 1 is granted in the same cycle as the retire.
- Reset mid-op: assert reset_n=0 with inflight=2 → rsp_valid=0 and inflight=0 immediately (asynchronously); after release, no spurious rsp_valid appears, and the first grant goes to requester 0.
